// File: rtl/ssriscv_wb_arbiter.sv
// rtl/ssriscv_wb_arbiter.sv - register-file writeback arbiter with long-latency scoreboard
//
// Purpose:
//   Shares the single register-file write port between the in-order pipeline
//   writeback (source 0) and the long-latency mul/div writeback (source 1).
//   Round-robin arbitration with valid/ready handshakes, a registered write
//   port, and a busy scoreboard of in-flight long-latency destinations that
//   drives the issue-stage hazard flags.
//
// Optional feature macro: SSRISCV_WB_BYPASS_EN
//   When defined, adds fwd1_hit/fwd2_hit/fwd_data. These forward the value
//   currently on the write port, and suppress the matching hazard flag.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   wb0_valid/ready/rd/data        source 0 (pipeline) writeback handshake
//   wb1_valid/ready/rd/data        source 1 (long-latency) writeback handshake
//   sb_set, sb_set_rd              mark a long-latency destination busy
//   rs1, rs2                       issue-stage source registers
//   hazard1, hazard2               pending long-latency write on rs1/rs2
//   reg_write, rd, reg_write_data  registered register-file write port
//   fwd1_hit, fwd2_hit, fwd_data   bypass outputs (SSRISCV_WB_BYPASS_EN only)

module ssriscv_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb0_valid,
  output logic             wb0_ready,
  input  logic [RADDR-1:0] wb0_rd,
  input  logic [XLEN-1:0]  wb0_data,
  input  logic             wb1_valid,
  output logic             wb1_ready,
  input  logic [RADDR-1:0] wb1_rd,
  input  logic [XLEN-1:0]  wb1_data,
  input  logic             sb_set,
  input  logic [RADDR-1:0] sb_set_rd,
  input  logic [RADDR-1:0] rs1,
  input  logic [RADDR-1:0] rs2,
  output logic             hazard1,
  output logic             hazard2,
`ifdef SSRISCV_WB_BYPASS_EN
  output logic             fwd1_hit,
  output logic             fwd2_hit,
  output logic [XLEN-1:0]  fwd_data,
`endif
  output logic             reg_write,
  output logic [RADDR-1:0] rd,
  output logic [XLEN-1:0]  reg_write_data
);

  localparam int NREG = 1 << RADDR;

  // pref_q=1 means source 1 wins the next tie. Storing "preferred next"
  // rather than "last granted" lets the reset value 0 favour source 0.
  logic             pref_q, pref_d;
  logic             reg_write_q, reg_write_d;
  logic [RADDR-1:0] rd_q, rd_d;
  logic [XLEN-1:0]  data_q, data_d;
  // Marks that the write currently on the port came from source 1, so the
  // scoreboard clears on the same edge the register file commits it.
  logic             src1_q, src1_d;
  logic [NREG-1:0]  busy_q, busy_d;

  logic             gnt0, gnt1, hs;
  logic [RADDR-1:0] sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic             haz1_raw, haz2_raw;

  always_comb begin
    gnt0     = wb0_valid & (~wb1_valid | ~pref_q);
    gnt1     = wb1_valid & (~wb0_valid |  pref_q);
    hs       = gnt0 | gnt1;
    sel_rd   = gnt1 ? wb1_rd   : wb0_rd;
    sel_data = gnt1 ? wb1_data : wb0_data;
  end

  assign wb0_ready = gnt0;
  assign wb1_ready = gnt1;

  always_comb begin
    pref_d      = pref_q;
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    data_d      = data_q;
    src1_d      = 1'b0;
    busy_d      = busy_q;

    if (hs) begin
      pref_d = gnt0;
    end

    // Writes to x0 complete the handshake but never reach the port; the
    // port keeps showing the last real write.
    if (hs && (sel_rd != '0)) begin
      reg_write_d = 1'b1;
      rd_d        = sel_rd;
      data_d      = sel_data;
      src1_d      = gnt1;
    end

    // Clear first so a same-edge set of the same index wins.
    if (reg_write_q && src1_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (sb_set && (sb_set_rd != '0)) begin
      busy_d[sb_set_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pref_q      <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
      src1_q      <= 1'b0;
      busy_q      <= '0;
    end else begin
      pref_q      <= pref_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      src1_q      <= src1_d;
      busy_q      <= busy_d;
    end
  end

  assign reg_write      = reg_write_q;
  assign rd             = rd_q;
  assign reg_write_data = data_q;

  assign haz1_raw = busy_q[rs1] & (rs1 != '0);
  assign haz2_raw = busy_q[rs2] & (rs2 != '0);

`ifdef SSRISCV_WB_BYPASS_EN
  assign fwd1_hit = reg_write_q & (rd_q == rs1) & (rs1 != '0);
  assign fwd2_hit = reg_write_q & (rd_q == rs2) & (rs2 != '0);
  assign fwd_data = data_q;
  assign hazard1  = haz1_raw & ~fwd1_hit;
  assign hazard2  = haz2_raw & ~fwd2_hit;
`else
  assign hazard1  = haz1_raw;
  assign hazard2  = haz2_raw;
`endif

endmodule

// File: tb/tb_ssriscv_wb_arbiter.sv
// tb/tb_ssriscv_wb_arbiter.sv - self-checking bench for ssriscv_wb_arbiter
module tb_ssriscv_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb0_valid = 1'b0, wb1_valid = 1'b0, sb_set = 1'b0;
  logic        wb0_ready, wb1_ready, hazard1, hazard2, reg_write;
  logic [4:0]  wb0_rd = '0, wb1_rd = '0, sb_set_rd = '0, rs1 = '0, rs2 = '0, rd;
  logic [31:0] wb0_data = '0, wb1_data = '0, reg_write_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ssriscv_wb_arbiter #(.XLEN(32), .RADDR(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .sb_set(sb_set), .sb_set_rd(sb_set_rd), .rs1(rs1), .rs2(rs2),
    .hazard1(hazard1), .hazard2(hazard2),
    .reg_write(reg_write), .rd(rd), .reg_write_data(reg_write_data)
  );

  typedef struct {
    logic        rst;
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        sb;
    logic [4:0]  sbrd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e0;
    logic        e1;
    logic        h1;
    logic        h2;
    logic        we;
    logic [4:0]  erd;
    logic [31:0] edat;
    logic        cp;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        cp;
  } exp_t;

  vec_t vecs[20];
  exp_t sbq[$];

  function automatic vec_t mk(
    input logic rst, input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
    input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
    input logic sb, input logic [4:0] sbrd, input logic [4:0] r1, input logic [4:0] r2,
    input logic e0, input logic e1, input logic h1, input logic h2,
    input logic we, input logic [4:0] erd, input logic [31:0] edat, input logic cp);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.rd0 = rd0; v.d0 = d0;
    v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
    v.sb = sb; v.sbrd = sbrd; v.r1 = r1; v.r2 = r2;
    v.e0 = e0; v.e1 = e1; v.h1 = h1; v.h2 = h2;
    v.we = we; v.erd = erd; v.edat = edat; v.cp = cp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                       input logic sb, input logic [4:0] sbrd, input logic [4:0] r1, input logic [4:0] r2);
    rst_n = r; wb0_valid = v0; wb0_rd = rd0; wb0_data = d0;
    wb1_valid = v1; wb1_rd = rd1; wb1_data = d1;
    sb_set = sb; sb_set_rd = sbrd; rs1 = r1; rs2 = r2;
  endtask

  task automatic pop_check(input int idx);
    exp_t e;
    if (sbq.size() == 0) begin
      chk($sformatf("queue_empty[%0d]", idx), 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("reg_write[%0d]", idx), {31'd0, reg_write}, {31'd0, e.we});
      if (e.cp) begin
        chk($sformatf("rd[%0d]", idx), {27'd0, rd}, {27'd0, e.rd});
        chk($sformatf("reg_write_data[%0d]", idx), reg_write_data, e.data);
      end
    end
  endtask

  initial begin
    //             rst v0 rd0 d0        v1 rd1 d1         sb sbrd rs1 rs2  e0 e1 h1 h2  we erd edat      cp
    vecs[0]  = mk(0, 0, 0,  0,        0, 0,  0,         0, 0,   0,  0,   0, 0, 0, 0,  0, 0,  0,        1);
    vecs[1]  = mk(1, 1, 5,  'h1234,   0, 0,  0,         0, 0,   0,  0,   1, 0, 0, 0,  1, 5,  'h1234,   1);
    vecs[2]  = mk(1, 0, 0,  0,        0, 0,  0,         0, 0,   0,  0,   0, 0, 0, 0,  0, 5,  'h1234,   1);
    vecs[3]  = mk(0, 0, 0,  0,        0, 0,  0,         0, 0,   0,  0,   0, 0, 0, 0,  0, 0,  0,        1);
    vecs[4]  = mk(1, 1, 1,  'h100,    1, 2,  'h200,     0, 0,   0,  0,   1, 0, 0, 0,  1, 1,  'h100,    1);
    vecs[5]  = mk(1, 1, 3,  'h300,    1, 2,  'h200,     0, 0,   0,  0,   0, 1, 0, 0,  1, 2,  'h200,    1);
    vecs[6]  = mk(1, 1, 3,  'h300,    1, 4,  'h400,     0, 0,   0,  0,   1, 0, 0, 0,  1, 3,  'h300,    1);
    vecs[7]  = mk(1, 1, 5,  'h500,    1, 4,  'h400,     0, 0,   0,  0,   0, 1, 0, 0,  1, 4,  'h400,    1);
    vecs[8]  = mk(1, 0, 0,  0,        0, 0,  0,         1, 7,   7,  0,   0, 0, 0, 0,  0, 4,  'h400,    1);
    vecs[9]  = mk(1, 0, 0,  0,        1, 7,  'h777,     0, 0,   7,  0,   0, 1, 1, 0,  1, 7,  'h777,    1);
    vecs[10] = mk(1, 0, 0,  0,        0, 0,  0,         0, 0,   7,  0,   0, 0, 1, 0,  0, 7,  'h777,    1);
    vecs[11] = mk(1, 0, 0,  0,        1, 0,  'hDEAD,    1, 0,   7,  0,   0, 1, 0, 0,  0, 0,  0,        0);
    vecs[12] = mk(1, 0, 0,  0,        0, 0,  0,         0, 0,   0,  0,   0, 0, 0, 0,  0, 0,  0,        0);
    vecs[13] = mk(1, 0, 0,  0,        1, 9,  'h999,     1, 9,   0,  9,   0, 1, 0, 0,  1, 9,  'h999,    1);
    vecs[14] = mk(1, 0, 0,  0,        0, 0,  0,         1, 9,   0,  9,   0, 0, 0, 1,  0, 9,  'h999,    1);
    vecs[15] = mk(1, 0, 0,  0,        0, 0,  0,         0, 0,   0,  9,   0, 0, 0, 1,  0, 9,  'h999,    1);
    vecs[16] = mk(0, 1, 6,  'hAA6,    0, 0,  0,         0, 0,   0,  9,   1, 0, 0, 1,  0, 0,  0,        1);
    vecs[17] = mk(1, 0, 0,  0,        0, 0,  0,         0, 0,   0,  9,   0, 0, 0, 0,  0, 0,  0,        1);
    vecs[18] = mk(1, 1, 10, 'hA,      1, 11, 'hB,       0, 0,   0,  0,   1, 0, 0, 0,  1, 10, 'hA,      1);
    vecs[19] = mk(1, 0, 0,  0,        0, 0,  0,         0, 0,   0,  0,   0, 0, 0, 0,  0, 10, 'hA,      1);

    for (int i = 0; i < 20; i++) begin
      exp_t e;
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].v0, vecs[i].rd0, vecs[i].d0, vecs[i].v1, vecs[i].rd1, vecs[i].d1,
            vecs[i].sb, vecs[i].sbrd, vecs[i].r1, vecs[i].r2);
      #1;
      chk($sformatf("wb0_ready[%0d]", i), {31'd0, wb0_ready}, {31'd0, vecs[i].e0});
      chk($sformatf("wb1_ready[%0d]", i), {31'd0, wb1_ready}, {31'd0, vecs[i].e1});
      chk($sformatf("hazard1[%0d]", i), {31'd0, hazard1}, {31'd0, vecs[i].h1});
      chk($sformatf("hazard2[%0d]", i), {31'd0, hazard2}, {31'd0, vecs[i].h2});
      e.we = vecs[i].we; e.rd = vecs[i].erd; e.data = vecs[i].edat; e.cp = vecs[i].cp;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      pop_check(i);
    end

    // Back-to-back source-0 writes: one write per cycle, each landing a cycle later.
    for (int k = 0; k < 8; k++) begin
      exp_t e;
      logic [4:0]  r;
      logic [31:0] d;
      r = 5'($urandom_range(1, 31));
      d = $urandom;
      @(negedge clk);
      drive(1'b1, 1'b1, r, d, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      chk($sformatf("burst_ready[%0d]", k), {31'd0, wb0_ready}, 32'd1);
      e.we = 1'b1; e.rd = r; e.data = d; e.cp = 1'b1;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      pop_check(100 + k);
    end

    // Source 1 held valid while source 0 keeps winning ties never starves: the
    // second tie must go to source 1.
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("tie_a_ready1", {31'd0, wb1_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("tie_a_rd", {27'd0, rd}, 32'd13);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd12, 32'hC0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("tie_b_ready0", {31'd0, wb0_ready}, 32'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("tie_b_data", reg_write_data, 32'hC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
